branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Fetch-side branch predictor. Produces the predicted next PC that travels down the pipe with each instruction.
- Trained from writeback with the resolved outcome of every control-flow instruction. The writeback-stage mispredict check compares the actual next PC against this prediction and raises flush.
- Direct-mapped BTB. Each entry holds a 2-bit saturating counter. Lookup is combinational in the fetch cycle; training writes are registered.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two, range 2..64.
- IDX_W, $clog2(ENTRIES), index width.
- TAG_W, 15-IDX_W, tag width (PC bit 0 is always 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_pc  input  16  PC of the instruction being fetched (lc3b_word).
- predict_addr  output  16  predicted next PC (lc3b_word).
- predict_taken  output  1  1 = prediction came from a BTB entry predicting taken.
- predict_hit  output  1  1 = valid entry with matching tag found.
- upd_valid  input  1  train strobe from writeback; one branch/jump/JSR/TRAP per cycle maximum.
- upd_pc  input  16  PC of the resolved control-flow instruction.
- upd_taken  input  1  actual outcome; unconditional transfers are driven 1.
- upd_target  input  16  actual target address when taken.

Behaviour:
- Address split: idx = pc[IDX_W:1], tag = pc[15:IDX_W+1].
- Entry state: valid (1), tag (TAG_W), target (16), ctr (2).
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == fetch_pc tag).
  - predict_taken = hit & ctr[idx][1].
  - predict_addr = predict_taken ? target[idx] : fetch_pc + 16'd2. Addition wraps modulo 2^16, so 0xFFFE gives 0x0000.
- Training on the rising clk edge when upd_valid = 1:
  - Hit & upd_taken: ctr saturating increment (11 stays 11); target := upd_target.
  - Hit & !upd_taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss & upd_taken: allocate. valid := 1, tag := upd_pc tag, target := upd_target, ctr := 2'b10 (weakly taken). Any aliasing entry is replaced.
  - Miss & !upd_taken: no state change; no allocation.
- Training is not visible to lookup until the cycle after the edge. There is no bypass, so a same-cycle lookup of the same PC returns the pre-update prediction.
- upd_valid = 0: no state change.
- Reset (asynchronous):
  - All valid := 0, ctr := 2'b01, tag := 0, target := 0.
  - Outputs react immediately as misses: predict_hit = 0, predict_taken = 0, predict_addr = fetch_pc + 2.
  - Reset asserted during a training cycle wins; that write is discarded.
  - First training accepted on the first rising edge after reset deasserts.
- Storage is flops, not RAM, so reset can clear it and lookup can be asynchronous.
- No stall input. Fetch holds fetch_pc steady while stalled, and the output follows combinationally.

Decomposition:
- lc3b_types gains:
  - btb_ctr_t (2-bit);
  - constants BTB_CTR_WEAK_TAKEN = 2'b10 and BTB_CTR_RESET = 2'b01.
  - Reuse lc3b_word for all 16-bit ports.
- Sub-module sat_counter2: a combinational 2-bit saturating up/down next-state function (inputs ctr, up; output next). It is instantiated once on the training path.
- Entry arrays stay in branch_target_buffer.

Test Plan:
- Post-reset miss: reset pulse, then fetch_pc = 0x3000 -> predict_hit = 0, predict_taken = 0, predict_addr = 0x3002.
- Allocate and predict:
  - Cycle 0: upd pc = 0x3004, taken = 1, target = 0x3020, with fetch_pc = 0x3004 in the same cycle -> predict_addr = 0x3006 (no bypass).
  - Cycle 1: fetch_pc = 0x3004 -> hit = 1, taken = 1, predict_addr = 0x3020.
- Counter hysteresis and saturation:
  - From ctr = 10 at pc 0x3004: four taken updates -> ctr = 11, still predicts 0x3020.
  - Then one not-taken -> ctr = 10, still taken.
  - Second not-taken -> ctr = 01, predict_addr = 0x3006, hit = 1.
  - Two more not-taken -> ctr = 00 and saturates there.
- Aliasing replacement:
  - After allocating 0x3004, update pc = 0x3024 (same idx 2), taken, target = 0x4000.
  - Lookup 0x3004 -> hit = 0, addr = 0x3006. Lookup 0x3024 -> addr = 0x4000.
  - A not-taken miss at 0x5008 leaves idx 4 invalid.
- Wrap and async reset:
  - fetch_pc = 0xFFFE on an empty BTB -> 0x0000.
  - With entries valid, assert reset between clock edges -> predict_hit drops to 0 before the next edge.
  - An upd_valid coincident with reset has no effect.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the branch target buffer counter type.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  btb_ctr_t;

  localparam btb_ctr_t BTB_CTR_WEAK_TAKEN = 2'b10;
  localparam btb_ctr_t BTB_CTR_RESET      = 2'b01;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
  import lc3b_types::*;
(
  input  btb_ctr_t ctr,
  input  logic     up,
  output btb_ctr_t next
);

  always_comb begin
    next = ctr;
    if (up) begin
      if (ctr != 2'b11) next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, registered training.
module branch_target_buffer
  import lc3b_types::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 15 - IDX_W
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word fetch_pc,
  output lc3b_word predict_addr,
  output logic     predict_taken,
  output logic     predict_hit,
  input  logic     upd_valid,
  input  lc3b_word upd_pc,
  input  logic     upd_taken,
  input  lc3b_word upd_target
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  lc3b_word         target_q [ENTRIES];
  btb_ctr_t         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  btb_ctr_t         ctr_next;
  logic             unused_upd_lsb;

  assign f_idx = fetch_pc[IDX_W:1];
  assign f_tag = fetch_pc[15:IDX_W+1];
  assign u_idx = upd_pc[IDX_W:1];
  assign u_tag = upd_pc[15:IDX_W+1];
  // Instructions are halfword aligned, so PC bit 0 never selects anything.
  assign unused_upd_lsb = upd_pc[0];

  // Fetch-side lookup
  always_comb begin
    predict_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    predict_taken = predict_hit && ctr_q[f_idx][1];
    predict_addr  = predict_taken ? target_q[f_idx] : fetch_pc + 16'd2;
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_counter2 u_ctr (
    .ctr  (ctr_q[u_idx]),
    .up   (upd_taken),
    .next (ctr_next)
  );

  // Writeback-side training; a miss that was not taken never allocates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BTB_CTR_RESET;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next;
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= BTB_CTR_WEAK_TAKEN;
      end
    end
  end

endmodule
